// File: rtl/mio_arb_pkg.sv
// mio_arbiter shared types and constants.
// State encoding, port indices and the abort fill pattern.
package mio_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_EXT = 1'b1;

    // Sliced down to DATA_W at the point of use.
    localparam logic [255:0] RDATA_ABORT = '1;

endpackage

// File: rtl/mio_arbiter_timeout.sv
// Access watchdog for mio_arbiter.
// Counts stalled ACCESS cycles; expired marks the last allowed one.
module mio_timeout #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [15:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= 16'd0;
        end else if (enable) begin
            count <= count + 16'd1;
        end
    end

    assign expired = (count == 16'(TIMEOUT - 1));

endmodule

// File: rtl/mio_arbiter.sv
// Two-port round-robin arbiter for the shared memory/IO bus.
// Port 0 is the CPU (ready0 drives MIO_ready), port 1 an external master.
module mio_arbiter
    import mio_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              ready0,
    output logic              ready1,
    output logic              err,
    output logic              grant,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    arb_state_t        state_q;
    arb_state_t        state_d;
    logic              last_grant_q;
    logic              grant_q;
    logic              abort_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;
    logic              win;
    logic              expired;
    logic              cap;
    logic [DATA_W-1:0] cap_data;

    // On a tie the port that did not own the last transaction wins.
    assign win = (req0 && req1) ? ~last_grant_q : req1;

    assign cap = (state_q == ACCESS) &&
                 ((mem_ack && !we_q) || (!mem_ack && expired));
    assign cap_data = mem_ack ? mem_rdata : RDATA_ABORT[DATA_W-1:0];

    mio_timeout #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (state_q != ACCESS),
        .enable ((state_q == ACCESS) && !mem_ack),
        .expired(expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (req0 || req1) state_d = ACCESS;
            ACCESS:  if (mem_ack || expired) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= PORT_EXT;
            grant_q      <= PORT_CPU;
            abort_q      <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            if (state_q == IDLE && (req0 || req1)) begin
                grant_q <= win;
                abort_q <= 1'b0;
                we_q    <= win ? we1 : we0;
                addr_q  <= win ? addr1 : addr0;
                wdata_q <= win ? wdata1 : wdata0;
            end
            if (state_q == ACCESS && !mem_ack && expired) begin
                abort_q <= 1'b1;
            end
            if (state_q == DONE) begin
                last_grant_q <= grant_q;
            end
            if (cap && grant_q == PORT_CPU) begin
                rdata0_q <= cap_data;
            end
            if (cap && grant_q == PORT_EXT) begin
                rdata1_q <= cap_data;
            end
        end
    end

    always_comb begin
        mem_req = (state_q == ACCESS);
        ready0  = (state_q == DONE) && (grant_q == PORT_CPU);
        ready1  = (state_q == DONE) && (grant_q == PORT_EXT);
        err     = (state_q == DONE) && abort_q;
    end

    assign grant     = grant_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign rdata0    = rdata0_q;
    assign rdata1    = rdata1_q;

endmodule

// File: tb/tb_mio_arbiter.sv
// Scoreboard bench for mio_arbiter: requesters queue expectations,
// a bus memory model answers, a monitor checks every completion.
module tb_mio_arbiter;

    localparam int TMO = 4;
    localparam logic [31:0] KEY = 32'h1234AB8D;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        tmo;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req = '0;
    logic [1:0]  we = '0;
    logic [31:0] addr [2];
    logic [31:0] wdata [2];
    logic [31:0] rdata0, rdata1;
    logic        ready0, ready1, err, grant;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;

    int checks = 0;
    int failures = 0;

    exp_t q0[$];
    exp_t q1[$];
    exp_t me;
    logic [31:0] mrd [2];
    logic        mon_en = 1'b1;
    logic [7:0]  ord_bits = '0;
    int          ord_n = 0;
    int          run = 0;
    int          last_run = 0;
    int          mrun = 0;
    logic        prev_ack = 1'b0;
    logic [64:0] bus_prev;
    logic [31:0] exp_rd;
    logic        mp;
    logic        have;

    always #5 clk = ~clk;

    mio_arbiter #(
        .ADDR_W (32),
        .DATA_W (32),
        .TIMEOUT(TMO)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req0     (req[0]),
        .req1     (req[1]),
        .we0      (we[0]),
        .we1      (we[1]),
        .addr0    (addr[0]),
        .addr1    (addr[1]),
        .wdata0   (wdata[0]),
        .wdata1   (wdata[1]),
        .rdata0   (rdata0),
        .rdata1   (rdata1),
        .ready0   (ready0),
        .ready1   (ready1),
        .err      (err),
        .grant    (grant),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ack  (mem_ack)
    );

    task automatic chk(input string name, input logic [64:0] act,
                       input logic [64:0] req_v);
        checks++;
        if (act !== req_v) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req_v);
        end
    endtask

    // Memory: data is a function of address; the ack delay is addr[2:0]
    // cycles into the access, and delays >= TMO never ack.
    always @(posedge clk) begin
        #1;
        if (mem_req) begin
            mrun++;
            mem_ack   = (mrun == int'(mem_addr[2:0]) + 1);
            mem_rdata = mem_addr ^ KEY;
        end else begin
            mrun = 0;
            mem_ack   = ($urandom_range(3, 0) == 0);
            mem_rdata = $urandom;
        end
    end

    always @(negedge clk) begin
        if (reset || !mon_en) begin
            run = 0;
            last_run = 0;
            prev_ack = 1'b0;
        end else begin
            chk("dual_ready", {64'd0, ready0 & ready1}, 65'd0);
            chk("err_no_ready", {64'd0, err & ~(ready0 | ready1)}, 65'd0);
            if (prev_ack) chk("ack_to_ready", {64'd0, ready0 | ready1}, 65'd1);
            if (mem_req) begin
                run++;
                if (run == 1) begin
                    have = grant ? (q1.size() != 0) : (q0.size() != 0);
                    chk("grant_has_req", {64'd0, have}, 65'd1);
                    if (have) begin
                        me = grant ? q1[0] : q0[0];
                        chk("bus_first", {mem_we, mem_addr, mem_wdata},
                            {me.we, me.addr, me.wdata});
                    end
                end else begin
                    chk("bus_hold", {mem_we, mem_addr, mem_wdata}, bus_prev);
                end
                bus_prev = {mem_we, mem_addr, mem_wdata};
            end else if (run != 0) begin
                last_run = run;
                run = 0;
            end
            prev_ack = mem_req && mem_ack;
            if (ready0 || ready1) begin
                mp = ready1;
                have = mp ? (q1.size() != 0) : (q0.size() != 0);
                chk("ready_expected", {64'd0, have}, 65'd1);
                if (have) begin
                    me = mp ? q1.pop_front() : q0.pop_front();
                    if (me.tmo) exp_rd = '1;
                    else if (me.we) exp_rd = mrd[mp];
                    else exp_rd = me.addr ^ KEY;
                    mrd[mp] = exp_rd;
                    chk("grant", {64'd0, grant}, {64'd0, mp});
                    chk("err", {64'd0, err}, {64'd0, me.tmo});
                    chk("rdata", {33'd0, mp ? rdata1 : rdata0}, {33'd0, exp_rd});
                    chk("rdata_other", {33'd0, mp ? rdata0 : rdata1},
                        {33'd0, mrd[!mp]});
                    chk("busy_cycles", 65'(last_run),
                        me.tmo ? 65'(TMO) : 65'(int'(me.addr[2:0]) + 1));
                end
                ord_bits = {ord_bits[6:0], mp};
                ord_n++;
            end
        end
    end

    task automatic issue(input int p, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input bit chaos);
        exp_t e;
        bit got;
        @(posedge clk);
        #1;
        req[p] = 1'b1;
        we[p] = w;
        addr[p] = a;
        wdata[p] = d;
        e.we = w;
        e.addr = a;
        e.wdata = d;
        e.tmo = (int'(a[2:0]) >= TMO);
        if (p == 0) q0.push_back(e);
        else q1.push_back(e);
        got = 0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if ((p == 0) ? ready0 : ready1) begin
                got = 1;
            end else if (chaos && mem_req && (int'(grant) == p)) begin
                addr[p] = $urandom;
                wdata[p] = $urandom;
                we[p] = 1'($urandom_range(1, 0));
                if ($urandom_range(1, 0) == 1) req[p] = 1'b0;
            end
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL ready_wait port=%0d actual=none required=ready", p);
        end
    endtask

    task automatic release_port(input int p);
        @(posedge clk);
        #1;
        req[p] = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        mrd[0] = '0;
        mrd[1] = '0;
    endtask

    task automatic rand_port(input int p);
        logic        w;
        logic [31:0] a;
        int          g;
        for (int i = 0; i < 30; i++) begin
            w = 1'($urandom_range(1, 0));
            a = $urandom;
            if (w) a[2] = 1'b0;
            issue(p, w, a, $urandom, 1'($urandom_range(1, 0)));
            g = $urandom_range(2, 0);
            if (g > 0) begin
                release_port(p);
                repeat (g - 1) @(posedge clk);
            end
        end
        release_port(p);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 2; i++) begin
            addr[i] = '0;
            wdata[i] = '0;
            mrd[i] = '0;
        end
        do_reset();
        @(negedge clk);
        chk("rst_ctrl", {59'd0, ready0, ready1, err, grant, mem_req, mem_we},
            65'd0);
        chk("rst_bus", {1'b0, mem_addr, mem_wdata}, 65'd0);
        chk("rst_rdata", {1'b0, rdata0, rdata1}, 65'd0);

        issue(0, 1'b0, 32'h40, 32'h0, 1'b0);
        release_port(0);

        do_reset();
        ord_n = 0;
        fork
            begin
                issue(0, 1'b0, 32'h11, 32'h0, 1'b0);
                issue(0, 1'b0, 32'h22, 32'h0, 1'b0);
                release_port(0);
            end
            begin
                issue(1, 1'b0, 32'h31, 32'h0, 1'b0);
                issue(1, 1'b0, 32'h42, 32'h0, 1'b0);
                release_port(1);
            end
        join
        chk("tie_order", {ord_n[31:0], 29'd0, ord_bits[3:0]},
            {32'd4, 29'd0, 4'b0101});

        issue(1, 1'b1, 32'h103, 32'hDEADBEEF, 1'b1);
        release_port(1);
        issue(0, 1'b0, 32'h44, 32'h0, 1'b0);
        issue(0, 1'b0, 32'h40, 32'h0, 1'b0);
        release_port(0);

        // Reset lands on the second access cycle of a stalled read.
        mon_en = 1'b0;
        @(posedge clk);
        #1;
        req[0] = 1'b1;
        we[0] = 1'b0;
        addr[0] = 32'h47;
        n = 0;
        @(negedge clk);
        while (!mem_req && n < 10) begin
            n++;
            @(negedge clk);
        end
        chk("rst_test_start", {64'd0, mem_req}, 65'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        req[0] = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        mrd[0] = '0;
        mrd[1] = '0;
        @(negedge clk);
        chk("rst_mem_req", {64'd0, mem_req}, 65'd0);
        for (int i = 0; i < 4; i++) begin
            chk("rst_no_ready", {64'd0, ready0 | ready1}, 65'd0);
            @(negedge clk);
        end
        mon_en = 1'b1;

        ord_n = 0;
        fork
            begin
                issue(0, 1'b0, 32'h58, 32'h0, 1'b0);
                release_port(0);
            end
            begin
                issue(1, 1'b0, 32'h61, 32'h0, 1'b0);
                release_port(1);
            end
        join
        chk("tie_after_reset", {ord_n[31:0], 31'd0, ord_bits[1:0]},
            {32'd2, 31'd0, 2'b01});

        fork
            rand_port(0);
            rand_port(1);
        join
        repeat (5) @(negedge clk);
        chk("queues_drained", 65'(q0.size() + q1.size()), 65'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mio_arbiter.md
# mio_arbiter

Two-port memory arbiter sharing the single memory/IO bus between the multi-cycle CPU (port 0, whose fetch and load/store states wait on `MIO_ready`) and a second master such as a DMA or display engine (port 1). It accepts one transaction at a time, grants round-robin on simultaneous requests, and drives the shared bus until the memory acknowledges. It returns a one-cycle ready pulse and read data to the winning requester. A timeout aborts stalled accesses.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `TIMEOUT`, 255, maximum ACCESS cycles without `mem_ack` before abort; legal range 1..65535

- `clk`  in  1  clock, rising edge
- `reset`  in  1  **one clock; reset is synchronous and active-high**
- `req0` / `req1`  in  1  transaction request, held high until the matching ready
- `we0` / `we1`  in  1  1 = write, 0 = read
- `addr0` / `addr1`  in  ADDR_W  byte address
- `wdata0` / `wdata1`  in  DATA_W  write data
- `rdata0` / `rdata1`  out  DATA_W  registered read data, valid when the matching ready is high
- `ready0` / `ready1`  out  1  one-cycle completion pulse; `ready0` feeds CPU `MIO_ready`
- `err`  out  1  one-cycle pulse coincident with ready on a timed-out transaction
- `grant`  out  1  owner of the current or most recent transaction
- `mem_req`  out  1  bus strobe
- `mem_we`  out  1  bus write enable
- `mem_addr`  out  ADDR_W  bus address
- `mem_wdata`  out  DATA_W  bus write data
- `mem_rdata`  in  DATA_W  bus read data, valid with `mem_ack`
- `mem_ack`  in  1  memory completion

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - If neither request is high, stay.
  - If exactly one is high, grant it.
  - If both are high, grant the port not equal to `last_grant`.
  - On a grant, latch `we`/`addr`/`wdata` of the winner into bus registers, set `grant`, clear the timer, and go to ACCESS.
- ACCESS:
  - `mem_req`=1; bus outputs come from the latched registers and do not change while in ACCESS.
  - On `mem_ack`: if read, capture `mem_rdata` into the winner's `rdata` register; go to DONE.
  - Otherwise increment the timer. When the timer equals `TIMEOUT-1` without ack, go to DONE with the abort flag set; the winner's `rdata` becomes all-ones.
- DONE: winner's `readyN`=1 (and `err`=1 if aborted); `last_grant` ← `grant`; go to IDLE.
- Once granted, a transaction completes even if `reqN` drops during ACCESS. Exactly one ready per grant.
- `mem_ack` outside ACCESS is ignored.
- Writes leave `rdata` unchanged. The non-winning port's `rdata` is never modified.
- Reset values: state IDLE; `last_grant`=1 (so port 0 wins the first tie); all outputs 0; `rdata0`/`rdata1`=0; timer 0.
- Reset mid-ACCESS drops `mem_req` at the next edge, issues no ready, and discards the transaction.

## Timing
- All outputs are registered.
- Request sampled high in IDLE at edge N: `mem_req` is high from cycle N+1.
- `mem_ack` sampled at edge M (M ≥ N+1): `readyN` and `rdata` are valid during cycle M+1.
- Minimum request-to-ready latency is 2 cycles (ack on the first ACCESS cycle).
- Back-to-back: IDLE occupies at least 1 cycle between transactions, so the minimum issue interval is 3 cycles.
- Requesters deassert `reqN` at the edge where they sample `readyN`. A `reqN` still high in the following IDLE cycle starts a new transaction.
- Timeout: `mem_req` is high for exactly `TIMEOUT` cycles, then DONE.

## Structure
- Package `mio_arb_pkg` holds:
  - state enum (IDLE=0, ACCESS=1, DONE=2, 2-bit encoding)
  - port index constants `PORT_CPU`=0, `PORT_EXT`=1
  - `RDATA_ABORT` fill pattern (all-ones)
- One sub-module, `mio_timeout`: a 16-bit counter with clear, enable, and `expired` = (count == `TIMEOUT-1`).
- Arbitration and bus registers live in the top module.

## Test plan
- `req0` only, read `addr0`=0x40, mem acks 1 cycle after `mem_req` with 0x1234ABCD → `mem_addr`=0x40, `mem_we`=0; `ready0` one cycle at request+2; `rdata0`=0x1234ABCD; `rdata1`=0.
- After reset, `req0` and `req1` rise together with repeated requests → order is 0,1,0,1; no cycle has both readys high.
- `req1` write 0xDEADBEEF to 0x100; `addr1` changes during ACCESS; ack delayed 5 cycles → bus outputs stay 0x100/0xDEADBEEF throughout ACCESS; `ready1` one cycle after ack; `rdata1` unchanged.
- `TIMEOUT`=4, no ack → `mem_req` high exactly 4 cycles; `ready0`, `err` pulse together; `rdata0`=0xFFFFFFFF; next transaction proceeds normally.
- `reset` asserted on the second ACCESS cycle → `mem_req` low the next cycle; no ready; state IDLE; a subsequent tie grants port 0.
- Spurious `mem_ack` in IDLE, and `req0` dropped mid-ACCESS → spurious ack ignored; `ready0` still pulses exactly once.
